health_tracker: RTL and testbench
=================================

Name: health_tracker

Overview:
- Parametrised per-fighter health and round-state tracker for the karateka game logic.
- Generalises the two-fighter hit counter to N fighters, each with:
  - health that counts down from a maximum, with saturation
  - a per-hit damage amount
  - post-hit invulnerability measured in frames
  - healing
  - death detection
- Adds round-level outcome flags (RoundOver, Winner, Draw) consumed by the game FSM and the HUD/health-bar renderer.

Parameters:
NUM_FIGHTERS, 2, number of independent fighter channels (>=2)
HEALTH_W, 9, width of each health value
MAX_HEALTH, 300, full-health value; must fit in HEALTH_W
DMG_W, 6, width of each damage/heal amount
IFRAMES, 30, invulnerability length in FrameTick pulses after an accepted hit (>=1)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset; one clock; priority over every other input
FrameTick  in  1  one-cycle pulse per video frame
RoundStart  in  1  one-cycle pulse; restores all fighters to full health
Hit  in  NUM_FIGHTERS  per-fighter hit strobe (bit i = fighter i was struck)
Damage  in  NUM_FIGHTERS*DMG_W  damage amount for fighter i, slice i
Heal  in  NUM_FIGHTERS  per-fighter heal strobe
HealAmt  in  NUM_FIGHTERS*DMG_W  heal amount for fighter i, slice i
Health  out  NUM_FIGHTERS*HEALTH_W  current health, slice i
Dead  out  NUM_FIGHTERS  fighter i health is 0
Invuln  out  NUM_FIGHTERS  fighter i is in its invulnerability window
RoundOver  out  1  round finished; sticky
Winner  out  $clog2(NUM_FIGHTERS)  index of the surviving fighter; valid only when RoundOver=1 and Draw=0
Draw  out  1  every fighter dead when the round ended

Behaviour:

Reset and RoundStart:
- Reset, or RoundStart outside Reset: every Health=MAX_HEALTH, state ALIVE, cooldown counter=0.
- After either: Dead=0, Invuln=0, RoundOver=0, Winner=0, Draw=0.
- RoundStart overrides Hit/Heal/FrameTick in the same cycle.

Per-fighter FSM (states ALIVE, INVULN, DEAD), all outputs registered:
- Accepted hit: Hit[i]=1, Damage[i]!=0, state ALIVE, RoundOver=0. Hit with Damage=0 is ignored.
- Accepted heal: Heal[i]=1, state ALIVE or INVULN, RoundOver=0.
- Next health = clamp(Health - acceptedDamage + acceptedHeal, 0, MAX_HEALTH).
  - Compute in HEALTH_W+2 signed bits; no wrap-around.
  - Hit and heal in the same cycle are netted in one update.
- Latency: Health is updated on the clock edge that samples the strobe; visible the next cycle.
- ALIVE, accepted hit, next health=0 -> DEAD.
- ALIVE, accepted hit, next health>0 -> INVULN; counter loads IFRAMES.
- INVULN:
  - Hits are ignored.
  - Counter decrements on each FrameTick.
  - A FrameTick seen with counter=1 -> ALIVE, counter=0.
  - Heals still apply.
- DEAD: absorbing until Reset/RoundStart. Hits and heals are ignored; Health holds 0.
- Output mapping: Dead[i] = (state==DEAD); Invuln[i] = (state==INVULN).

Round logic:
- RoundOver sets the cycle after the number of alive fighters first becomes <=1; registered from Dead.
- While RoundOver=1: all Hit/Heal are ignored and Health is frozen. The FrameTick cooldown continues.
- Winner latches at the same edge as RoundOver: lowest index with Dead=0.
- Draw=1 if all fighters are dead at that edge, e.g. simultaneous final blows.
- RoundOver, Winner and Draw hold until Reset/RoundStart.

Boundary cases:
- Damage > Health -> Health=0 (saturate).
- Heal past MAX_HEALTH -> Health=MAX_HEALTH.
- Reset in the middle of a cooldown or after RoundOver fully clears all state in one cycle.

Decomposition:
- Package health_pkg holds:
  - typedef enum logic [1:0] fighter_state_t {ALIVE, INVULN, DEAD}
  - default constants MAX_HEALTH_DEF and IFRAMES_DEF
  - function sat_update(health, dmg, heal, max) returning the clamped value
- Sub-module fighter_health: one channel containing the FSM, cooldown counter and health register.
- health_tracker generates NUM_FIGHTERS instances and adds the round-outcome logic.

Test Plan:
- Reset high one cycle -> Health all =300, Dead=0, Invuln=0, RoundOver=0, Draw=0.
- Hit[0] with Damage=25 -> next cycle Health[0]=275, Invuln[0]=1. Hit[0] again with Damage=40 before 30 FrameTicks -> Health[0] stays 275. On the 30th FrameTick -> Invuln[0]=0.
- Health[1]=10, Hit[1] with Damage=63 -> Health[1]=0, Dead[1]=1. Next cycle RoundOver=1, Winner=0, Draw=0. Further Hit/Heal have no effect.
- Health[0]=290 with Heal[0]=1, HealAmt=20 -> Health[0]=300 (saturated). Hit=1, Damage=5 with Heal=1, HealAmt=3 from 100 -> 98 and INVULN entered.
- Both fighters at 5, both hit with Damage=10 in the same cycle -> both Dead, RoundOver=1, Draw=1.
- RoundStart asserted in the same cycle as Hit[0], and Reset asserted in the middle of INVULN -> all Health=300, all flags cleared, the hit is not applied.

Source files
------------

// File: rtl/health_pkg.sv
// Shared types, defaults and the saturating health update for the fighter health tracker.
// No ports; imported by fighter_health and health_tracker.
package health_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } fighter_state_t;

  localparam int unsigned MAX_HEALTH_DEF = 300;
  localparam int unsigned IFRAMES_DEF    = 30;

  // Net damage and heal in one signed update, clamped to [0, max_h]. Plain int arithmetic
  // is wider than HEALTH_W+2 for any practical health width, so the difference never wraps.
  function automatic int sat_update(input int health, input int dmg, input int heal,
                                    input int max_h);
    int sum;
    sum = health - dmg + heal;
    if (sum < 0) return 0;
    if (sum > max_h) return max_h;
    return sum;
  endfunction

endpackage

// File: rtl/fighter_health.sv
// One fighter channel: health register, ALIVE/INVULN/DEAD state machine and the
// post-hit invulnerability cooldown counted in frame ticks.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   frame_tick_i        one pulse per video frame, drives the cooldown
//   round_start_i       restore full health, same effect as reset
//   frozen_i            round is over: hits and heals ignored, cooldown keeps running
//   hit_i, damage_i     hit strobe and damage amount
//   heal_i, heal_amt_i  heal strobe and heal amount
//   health_o            current health (registered)
//   dead_o, invuln_o    state decodes (registered)
module fighter_health
  import health_pkg::*;
#(
  parameter int unsigned HEALTH_W   = 9,
  parameter int unsigned DMG_W      = 6,
  parameter int unsigned MAX_HEALTH = MAX_HEALTH_DEF,
  parameter int unsigned IFRAMES    = IFRAMES_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                frame_tick_i,
  input  logic                round_start_i,
  input  logic                frozen_i,
  input  logic                hit_i,
  input  logic [DMG_W-1:0]    damage_i,
  input  logic                heal_i,
  input  logic [DMG_W-1:0]    heal_amt_i,
  output logic [HEALTH_W-1:0] health_o,
  output logic                dead_o,
  output logic                invuln_o
);

  localparam int unsigned CntW = $clog2(IFRAMES + 1);

  fighter_state_t      state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [HEALTH_W-1:0] health_q, health_d;

  logic                hit_ok, heal_ok;
  logic [DMG_W-1:0]    acc_dmg, acc_heal;
  logic [HEALTH_W-1:0] health_nxt;

  always_comb begin
    // A zero-damage hit is not a hit: it must not start invulnerability.
    hit_ok     = hit_i && (damage_i != '0) && (state_q == ALIVE) && !frozen_i;
    heal_ok    = heal_i && (state_q != DEAD) && !frozen_i;
    acc_dmg    = hit_ok ? damage_i : '0;
    acc_heal   = heal_ok ? heal_amt_i : '0;
    health_nxt = HEALTH_W'(sat_update(int'(health_q), int'(acc_dmg), int'(acc_heal),
                                      int'(MAX_HEALTH)));

    state_d  = state_q;
    cnt_d    = cnt_q;
    health_d = health_q;

    if (round_start_i) begin
      state_d  = ALIVE;
      cnt_d    = '0;
      health_d = HEALTH_W'(MAX_HEALTH);
    end else begin
      unique case (state_q)
        ALIVE: begin
          health_d = health_nxt;
          if (hit_ok) begin
            if (health_nxt == '0) begin
              state_d = DEAD;
            end else begin
              state_d = INVULN;
              cnt_d   = CntW'(IFRAMES);
            end
          end
        end
        INVULN: begin
          health_d = health_nxt;
          if (frame_tick_i) begin
            if (cnt_q == CntW'(1)) begin
              state_d = ALIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
        end
        DEAD: begin
          // Absorbing; health already 0.
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ALIVE;
      cnt_q    <= '0;
      health_q <= HEALTH_W'(MAX_HEALTH);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      health_q <= health_d;
    end
  end

  assign health_o = health_q;
  assign dead_o   = (state_q == DEAD);
  assign invuln_o = (state_q == INVULN);

endmodule

// File: rtl/health_tracker.sv
// N-fighter health tracker: one fighter_health channel per fighter plus the sticky
// round outcome (RoundOver, Winner, Draw) for the game FSM and HUD.
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   FrameTick           one pulse per video frame
//   RoundStart          restore every fighter and clear the round outcome
//   Hit/Damage          per-fighter hit strobes and damage slices
//   Heal/HealAmt        per-fighter heal strobes and heal slices
//   Health              per-fighter health slices
//   Dead, Invuln        per-fighter state flags
//   RoundOver           sticky, set the cycle after at most one fighter remains alive
//   Winner              lowest surviving index, valid when RoundOver and !Draw
//   Draw                every fighter dead when the round ended
module health_tracker
  import health_pkg::*;
#(
  parameter int unsigned NUM_FIGHTERS = 2,
  parameter int unsigned HEALTH_W     = 9,
  parameter int unsigned MAX_HEALTH   = MAX_HEALTH_DEF,
  parameter int unsigned DMG_W        = 6,
  parameter int unsigned IFRAMES      = IFRAMES_DEF
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               FrameTick,
  input  logic                               RoundStart,
  input  logic [NUM_FIGHTERS-1:0]            Hit,
  input  logic [NUM_FIGHTERS*DMG_W-1:0]      Damage,
  input  logic [NUM_FIGHTERS-1:0]            Heal,
  input  logic [NUM_FIGHTERS*DMG_W-1:0]      HealAmt,
  output logic [NUM_FIGHTERS*HEALTH_W-1:0]   Health,
  output logic [NUM_FIGHTERS-1:0]            Dead,
  output logic [NUM_FIGHTERS-1:0]            Invuln,
  output logic                               RoundOver,
  output logic [$clog2(NUM_FIGHTERS)-1:0]    Winner,
  output logic                               Draw
);

  localparam int unsigned WinW   = $clog2(NUM_FIGHTERS);
  localparam int unsigned AliveW = $clog2(NUM_FIGHTERS + 1);

  logic            round_over_q, round_over_d;
  logic [WinW-1:0] winner_q, winner_d, winner_nxt;
  logic            draw_q, draw_d;
  logic [AliveW-1:0] alive_cnt;

  for (genvar i = 0; i < NUM_FIGHTERS; i++) begin : g_fighter
    fighter_health #(
      .HEALTH_W  (HEALTH_W),
      .DMG_W     (DMG_W),
      .MAX_HEALTH(MAX_HEALTH),
      .IFRAMES   (IFRAMES)
    ) u_fighter (
      .clk_i        (Clk),
      .rst_i        (Reset),
      .frame_tick_i (FrameTick),
      .round_start_i(RoundStart),
      .frozen_i     (round_over_q),
      .hit_i        (Hit[i]),
      .damage_i     (Damage[i*DMG_W +: DMG_W]),
      .heal_i       (Heal[i]),
      .heal_amt_i   (HealAmt[i*DMG_W +: DMG_W]),
      .health_o     (Health[i*HEALTH_W +: HEALTH_W]),
      .dead_o       (Dead[i]),
      .invuln_o     (Invuln[i])
    );
  end

  always_comb begin
    // Scan downwards so the last assignment leaves the lowest surviving index.
    alive_cnt  = '0;
    winner_nxt = '0;
    for (int i = int'(NUM_FIGHTERS) - 1; i >= 0; i--) begin
      if (!Dead[i]) begin
        alive_cnt  = alive_cnt + AliveW'(1);
        winner_nxt = WinW'(i);
      end
    end

    round_over_d = round_over_q;
    winner_d     = winner_q;
    draw_d       = draw_q;

    if (RoundStart) begin
      round_over_d = 1'b0;
      winner_d     = '0;
      draw_d       = 1'b0;
    end else if (!round_over_q && (alive_cnt <= AliveW'(1))) begin
      round_over_d = 1'b1;
      winner_d     = winner_nxt;
      draw_d       = (alive_cnt == '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      round_over_q <= 1'b0;
      winner_q     <= '0;
      draw_q       <= 1'b0;
    end else begin
      round_over_q <= round_over_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
    end
  end

  assign RoundOver = round_over_q;
  assign Winner    = winner_q;
  assign Draw      = draw_q;

endmodule

// File: tb/tb_health_tracker.sv
// Self-checking bench for health_tracker: directed scenarios followed by random stimulus,
// every cycle compared against an integer reference model of the fighter rules.
module tb_health_tracker;

  localparam int N    = 2;
  localparam int HW   = 9;
  localparam int DW   = 6;
  localparam int MAXH = 300;
  localparam int IFR  = 30;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b0;
  logic                 FrameTick = 1'b0;
  logic                 RoundStart = 1'b0;
  logic [N-1:0]         Hit = '0;
  logic [N*DW-1:0]      Damage = '0;
  logic [N-1:0]         Heal = '0;
  logic [N*DW-1:0]      HealAmt = '0;
  logic [N*HW-1:0]      Health;
  logic [N-1:0]         Dead;
  logic [N-1:0]         Invuln;
  logic                 RoundOver;
  logic [$clog2(N)-1:0] Winner;
  logic                 Draw;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: 0 = alive, 1 = invulnerable, 2 = dead.
  int m_health[N];
  int m_state[N];
  int m_cd[N];
  int m_ro, m_win, m_draw;

  health_tracker #(
    .NUM_FIGHTERS(N),
    .HEALTH_W    (HW),
    .MAX_HEALTH  (MAXH),
    .DMG_W       (DW),
    .IFRAMES     (IFR)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .FrameTick (FrameTick),
    .RoundStart(RoundStart),
    .Hit       (Hit),
    .Damage    (Damage),
    .Heal      (Heal),
    .HealAmt   (HealAmt),
    .Health    (Health),
    .Dead      (Dead),
    .Invuln    (Invuln),
    .RoundOver (RoundOver),
    .Winner    (Winner),
    .Draw      (Draw)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int hp(input int i);
    return int'(Health[i*HW +: HW]);
  endfunction

  task automatic set_dmg(input int i, input int v);
    Damage[i*DW +: DW] = DW'(v);
  endtask

  task automatic set_heal(input int i, input int v);
    HealAmt[i*DW +: DW] = DW'(v);
  endtask

  task automatic model_step();
    int alive, win, ro_old, d, h, acc_d, acc_h, nh;
    if (Reset || RoundStart) begin
      for (int i = 0; i < N; i++) begin
        m_health[i] = MAXH;
        m_state[i]  = 0;
        m_cd[i]     = 0;
      end
      m_ro = 0; m_win = 0; m_draw = 0;
    end else begin
      alive = 0;
      win   = -1;
      for (int i = 0; i < N; i++) begin
        if (m_state[i] != 2) begin
          alive++;
          if (win < 0) win = i;
        end
      end
      ro_old = m_ro;
      if (m_ro == 0 && alive <= 1) begin
        m_ro   = 1;
        m_win  = (win < 0) ? 0 : win;
        m_draw = (alive == 0) ? 1 : 0;
      end
      for (int i = 0; i < N; i++) begin
        d = int'(Damage[i*DW +: DW]);
        h = int'(HealAmt[i*DW +: DW]);
        acc_d = (Hit[i] && d != 0 && m_state[i] == 0 && ro_old == 0) ? d : 0;
        acc_h = (Heal[i] && m_state[i] != 2 && ro_old == 0) ? h : 0;
        nh = m_health[i] - acc_d + acc_h;
        if (nh < 0) nh = 0;
        if (nh > MAXH) nh = MAXH;
        if (m_state[i] == 0) begin
          m_health[i] = nh;
          if (acc_d != 0) begin
            if (nh == 0) m_state[i] = 2;
            else begin
              m_state[i] = 1;
              m_cd[i]    = IFR;
            end
          end
        end else if (m_state[i] == 1) begin
          m_health[i] = nh;
          if (FrameTick) begin
            if (m_cd[i] == 1) begin
              m_state[i] = 0;
              m_cd[i]    = 0;
            end else m_cd[i] = m_cd[i] - 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("health%0d", i), Health[i*HW +: HW], m_health[i]);
      check($sformatf("dead%0d", i), Dead[i], (m_state[i] == 2) ? 1 : 0);
      check($sformatf("invuln%0d", i), Invuln[i], (m_state[i] == 1) ? 1 : 0);
    end
    check("round_over", RoundOver, m_ro);
    check("draw", Draw, m_draw);
    if (!(m_ro == 1 && m_draw == 1)) check("winner", Winner, m_win);
  endtask

  // One clock: model and DUT advance on the same edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge Clk);
    model_step();
    #1;
    check_all();
    Reset = 1'b0; RoundStart = 1'b0; FrameTick = 1'b0; Hit = '0; Heal = '0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      FrameTick = 1'b1;
      step();
    end
  endtask

  // Hit every fighter in mask with dmg, then sit out the invulnerability window.
  task automatic strike(input int mask, input int dmg);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        Hit[i] = 1'b1;
        set_dmg(i, dmg);
      end
    end
    step();
    frames(IFR);
  endtask

  initial begin
    Reset = 1'b1;
    step();
    check("rst_h0", hp(0), 300);
    check("rst_h1", hp(1), 300);
    check("rst_ro", RoundOver, 0);

    Hit[0] = 1'b1; set_dmg(0, 25); step();
    check("hit_h0", hp(0), 275);
    check("hit_inv0", Invuln[0], 1);
    Hit[0] = 1'b1; set_dmg(0, 40); step();
    check("inv_ignore_hit", hp(0), 275);
    frames(IFR - 1);
    check("inv_before_last_tick", Invuln[0], 1);
    frames(1);
    check("inv_after_last_tick", Invuln[0], 0);

    Heal[0] = 1'b1; set_heal(0, 15); step();
    check("heal_h0", hp(0), 290);
    Heal[0] = 1'b1; set_heal(0, 20); step();
    check("heal_sat_h0", hp(0), 300);

    strike(1, 63); strike(1, 63); strike(1, 63); strike(1, 11);
    check("h0_at_100", hp(0), 100);
    Hit[0] = 1'b1; set_dmg(0, 5); Heal[0] = 1'b1; set_heal(0, 3); step();
    check("net_h0", hp(0), 98);
    check("net_inv0", Invuln[0], 1);
    frames(IFR);

    strike(2, 63); strike(2, 63); strike(2, 63); strike(2, 63); strike(2, 38);
    check("h1_at_10", hp(1), 10);
    Hit[1] = 1'b1; set_dmg(1, 63); step();
    check("kill_h1", hp(1), 0);
    check("kill_dead1", Dead[1], 1);
    check("kill_ro_not_yet", RoundOver, 0);
    step();
    check("ro_set", RoundOver, 1);
    check("ro_winner", Winner, 0);
    check("ro_draw", Draw, 0);
    Hit[0] = 1'b1; set_dmg(0, 30); Heal[1] = 1'b1; set_heal(1, 10); step();
    check("frozen_h0", hp(0), 98);
    check("frozen_h1", hp(1), 0);

    RoundStart = 1'b1; step();
    check("rs_h1", hp(1), 300);
    check("rs_ro", RoundOver, 0);
    strike(3, 63); strike(3, 63); strike(3, 63); strike(3, 63); strike(3, 43);
    check("both_at_5", hp(0) + hp(1), 10);
    Hit = 2'b11; set_dmg(0, 10); set_dmg(1, 10); step();
    check("both_dead", Dead, 2'b11);
    step();
    check("draw_ro", RoundOver, 1);
    check("draw_flag", Draw, 1);

    RoundStart = 1'b1; Hit[0] = 1'b1; set_dmg(0, 20); step();
    check("rs_over_hit_h0", hp(0), 300);
    check("rs_over_hit_inv0", Invuln[0], 0);
    check("rs_clear_draw", Draw, 0);
    Hit[0] = 1'b1; set_dmg(0, 20); step();
    frames(5);
    check("mid_inv0", Invuln[0], 1);
    Reset = 1'b1; step();
    check("rst_mid_h0", hp(0), 300);
    check("rst_mid_inv0", Invuln[0], 0);

    for (int c = 0; c < 6000; c++) begin
      Reset      = ($urandom_range(399) == 0);
      RoundStart = ($urandom_range(249) == 0);
      FrameTick  = ($urandom_range(2) == 0);
      for (int i = 0; i < N; i++) begin
        Hit[i]  = ($urandom_range(3) == 0);
        set_dmg(i, int'($urandom_range(63)));
        Heal[i] = ($urandom_range(5) == 0);
        set_heal(i, int'($urandom_range(63)));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
